// File: rtl/if_id_skid.sv
// IF/ID boundary buffer: head register plus one skid register, in-order, flushable.
// in_ready depends only on the state register, so fetch never sees a combinational path from decode.
module if_id_skid #(
  parameter int XLEN    = 32,
  parameter int INSTR_W = 32,
  parameter int CNT_W   = 16
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [XLEN-1:0]    in_pc,
  input  logic [INSTR_W-1:0] in_instr,
  input  logic               flush,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [XLEN-1:0]    out_pc,
  output logic [INSTR_W-1:0] out_instr,
  output logic [1:0]         occupancy,
  output logic [CNT_W-1:0]   flush_cnt,
  output logic [CNT_W-1:0]   stall_cnt
);

  // Handshake: an entry moves on a port only in a cycle where valid and ready are both high
  // at the rising edge and flush is low; flush discards the offered entry and everything held.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t             r_state;
  logic [XLEN-1:0]    r_head_pc;
  logic [INSTR_W-1:0] r_head_instr;
  logic [XLEN-1:0]    r_skid_pc;
  logic [INSTR_W-1:0] r_skid_instr;
  logic [CNT_W-1:0]   r_flush_cnt;
  logic [CNT_W-1:0]   r_stall_cnt;

  logic w_accept;
  logic w_pop;
  logic w_stall;

  always_comb begin
    in_ready  = (r_state != TWO);
    out_valid = (r_state != EMPTY);
    w_accept  = in_valid & in_ready & ~flush;
    w_pop     = out_valid & out_ready & ~flush;
    w_stall   = out_valid & ~out_ready & ~flush;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state      <= EMPTY;
      r_head_pc    <= '0;
      r_head_instr <= '0;
      r_skid_pc    <= '0;
      r_skid_instr <= '0;
      r_flush_cnt  <= '0;
      r_stall_cnt  <= '0;
    end else begin
      // Flush clears validity only; the data registers keep their last contents.
      if (flush) begin
        r_state <= EMPTY;
      end else begin
        case (r_state)
          EMPTY: begin
            if (w_accept) begin
              r_state      <= ONE;
              r_head_pc    <= in_pc;
              r_head_instr <= in_instr;
            end
          end
          ONE: begin
            if (w_accept && w_pop) begin
              r_head_pc    <= in_pc;
              r_head_instr <= in_instr;
            end else if (w_accept) begin
              r_state      <= TWO;
              r_skid_pc    <= in_pc;
              r_skid_instr <= in_instr;
            end else if (w_pop) begin
              r_state <= EMPTY;
            end
          end
          TWO: begin
            if (w_pop) begin
              r_state      <= ONE;
              r_head_pc    <= r_skid_pc;
              r_head_instr <= r_skid_instr;
            end
          end
          default: r_state <= EMPTY;
        endcase
      end

      if (flush && (r_flush_cnt != '1))
        r_flush_cnt <= r_flush_cnt + CNT_ONE;
      if (w_stall && (r_stall_cnt != '1))
        r_stall_cnt <= r_stall_cnt + CNT_ONE;
    end
  end

  assign out_pc    = r_head_pc;
  assign out_instr = r_head_instr;
  assign occupancy = r_state;
  assign flush_cnt = r_flush_cnt;
  assign stall_cnt = r_stall_cnt;

endmodule

// File: tb/tb_if_id_skid.sv
// Bench for if_id_skid: queue-based reference model checked every cycle, plus directed
// scenarios with literal expectations (ordering, flush, streaming, saturation, reset).
module tb_if_id_skid;

  localparam int XLEN    = 32;
  localparam int INSTR_W = 32;

  // ---------------- clock / reset / DUT ----------------
  logic               clock = 1'b0;
  logic               reset;
  logic               in_valid;
  logic               in_ready;
  logic [XLEN-1:0]    in_pc;
  logic [INSTR_W-1:0] in_instr;
  logic               flush;
  logic               out_valid;
  logic               out_ready;
  logic [XLEN-1:0]    out_pc;
  logic [INSTR_W-1:0] out_instr;
  logic [1:0]         occupancy;
  logic [15:0]        flush_cnt;
  logic [15:0]        stall_cnt;

  logic               d4_in_ready;
  logic               d4_out_valid;
  logic [XLEN-1:0]    d4_out_pc;
  logic [INSTR_W-1:0] d4_out_instr;
  logic [1:0]         d4_occupancy;
  logic [3:0]         d4_flush_cnt;
  logic [3:0]         d4_stall_cnt;

  always #5 clock = ~clock;

  if_id_skid #(.XLEN(XLEN), .INSTR_W(INSTR_W), .CNT_W(16)) dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_pc(in_pc), .in_instr(in_instr), .flush(flush), .out_valid(out_valid),
    .out_ready(out_ready), .out_pc(out_pc), .out_instr(out_instr),
    .occupancy(occupancy), .flush_cnt(flush_cnt), .stall_cnt(stall_cnt)
  );

  if_id_skid #(.XLEN(XLEN), .INSTR_W(INSTR_W), .CNT_W(4)) dut4 (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(d4_in_ready),
    .in_pc(in_pc), .in_instr(in_instr), .flush(flush), .out_valid(d4_out_valid),
    .out_ready(out_ready), .out_pc(d4_out_pc), .out_instr(d4_out_instr),
    .occupancy(d4_occupancy), .flush_cnt(d4_flush_cnt), .stall_cnt(d4_stall_cnt)
  );

  // ---------------- scoreboard bookkeeping ----------------
  int n_cmp = 0;
  int n_err = 0;
  bit check_en = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // The buffer is a FIFO of at most two entries; the visible head is the oldest held entry,
  // or whatever was last shown once the buffer drains.
  logic [63:0]        exp_q[$];
  logic [XLEN-1:0]    m_pc;
  logic [INSTR_W-1:0] m_instr;
  int                 m_flush;
  int                 m_stall;

  always @(posedge clock) begin
    if (reset) begin
      exp_q.delete();
      m_pc = '0;
      m_instr = '0;
      m_flush = 0;
      m_stall = 0;
    end else if (flush) begin
      exp_q.delete();
      m_flush++;
    end else begin
      automatic bit had = (exp_q.size() > 0);
      automatic bit room = (exp_q.size() < 2);
      if (had && !out_ready) m_stall++;
      if (had && out_ready) void'(exp_q.pop_front());
      if (in_valid && room) exp_q.push_back({in_pc, in_instr});
    end
    if (exp_q.size() > 0) {m_pc, m_instr} = exp_q[0];
  end

  function automatic logic [63:0] sat(input int v, input int maxv);
    return (v > maxv) ? 64'(maxv) : 64'(v);
  endfunction

  // ---------------- per-cycle compare ----------------
  always @(negedge clock) begin
    if (check_en) begin
      chk("in_ready",   {63'b0, in_ready},  {63'b0, exp_q.size() < 2});
      chk("out_valid",  {63'b0, out_valid}, {63'b0, exp_q.size() > 0});
      chk("occupancy",  64'(occupancy),     64'(exp_q.size()));
      chk("out_pc",     64'(out_pc),        64'(m_pc));
      chk("out_instr",  64'(out_instr),     64'(m_instr));
      chk("flush_cnt",  64'(flush_cnt),     sat(m_flush, 65535));
      chk("stall_cnt",  64'(stall_cnt),     sat(m_stall, 65535));
      chk("flush_cnt4", 64'(d4_flush_cnt),  sat(m_flush, 15));
      chk("stall_cnt4", 64'(d4_stall_cnt),  sat(m_stall, 15));
      chk("occupancy4", 64'(d4_occupancy),  64'(exp_q.size()));
    end
  end

  // Log of PCs actually handed to decode, compared against literal lists.
  logic [XLEN-1:0] got_q[$];
  always @(posedge clock) begin
    if (!reset && !flush && out_valid && out_ready) got_q.push_back(out_pc);
  end

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    reset = 1'b1;
    in_valid = 1'b0;
    flush = 1'b0;
    out_ready = 1'b0;
    in_pc = '0;
    in_instr = '0;
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
    got_q.delete();
  endtask

  // Holds the offer until the buffer takes it; caller starts just after a rising edge.
  task automatic offer(input logic [XLEN-1:0] pc, input logic [INSTR_W-1:0] instr);
    bit taken = 1'b0;
    in_valid = 1'b1;
    in_pc = pc;
    in_instr = instr;
    for (int k = 0; k < 50 && !taken; k++) begin
      @(negedge clock);
      if (in_ready && !flush) taken = 1'b1;
      @(posedge clock);
      #1;
    end
    in_valid = 1'b0;
    chk("offer_taken", {63'b0, taken}, 64'd1);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  // ---------------- directed scenarios ----------------
  initial begin
    reset = 1'b1;
    in_valid = 1'b0;
    flush = 1'b0;
    out_ready = 1'b0;
    in_pc = '0;
    in_instr = '0;
    @(posedge clock);
    #1;
    check_en = 1'b1;

    // Reset state and single-entry latency.
    do_reset();
    chk("rst_in_ready", {63'b0, in_ready}, 64'd1);
    chk("rst_occ", 64'(occupancy), 64'd0);
    chk("rst_out_pc", 64'(out_pc), 64'd0);
    in_valid = 1'b1; in_pc = 32'h100; in_instr = 32'h0000_0013; out_ready = 1'b1;
    idle(1);
    in_valid = 1'b0;
    chk("lat_out_valid", {63'b0, out_valid}, 64'd1);
    chk("lat_out_pc", 64'(out_pc), 64'h100);
    chk("lat_out_instr", 64'(out_instr), 64'h13);
    chk("lat_occ", 64'(occupancy), 64'd1);
    idle(2);

    // Back-pressure: fill, third offer held off, then drain in order.
    do_reset();
    out_ready = 1'b0;
    offer(32'h100, 32'hA0);
    chk("bp_occ1", 64'(occupancy), 64'd1);
    offer(32'h104, 32'hA4);
    chk("bp_occ2", 64'(occupancy), 64'd2);
    chk("bp_in_ready", {63'b0, in_ready}, 64'd0);
    in_valid = 1'b1; in_pc = 32'h108; in_instr = 32'hA8;
    idle(1);
    chk("bp_held_occ", 64'(occupancy), 64'd2);
    chk("bp_held_pc", 64'(out_pc), 64'h100);
    out_ready = 1'b1;
    offer(32'h108, 32'hA8);
    idle(3);
    chk("bp_pop_cnt", 64'(got_q.size()), 64'd3);
    if (got_q.size() == 3) begin
      chk("bp_order0", 64'(got_q[0]), 64'h100);
      chk("bp_order1", 64'(got_q[1]), 64'h104);
      chk("bp_order2", 64'(got_q[2]), 64'h108);
    end
    chk("bp_stall", 64'(stall_cnt), 64'd2);

    // Flush while full, with a simultaneous offer and pop request.
    do_reset();
    out_ready = 1'b0;
    offer(32'h100, 32'hB0);
    offer(32'h104, 32'hB4);
    flush = 1'b1; in_valid = 1'b1; in_pc = 32'h200; in_instr = 32'hC0; out_ready = 1'b1;
    idle(1);
    flush = 1'b0; in_valid = 1'b0;
    chk("fl_occ", 64'(occupancy), 64'd0);
    chk("fl_out_valid", {63'b0, out_valid}, 64'd0);
    chk("fl_out_pc", 64'(out_pc), 64'h100);
    chk("fl_flush_cnt", 64'(flush_cnt), 64'd1);
    idle(4);
    chk("fl_nothing_out", 64'(got_q.size()), 64'd0);

    // Streaming at full throughput.
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 100; i++) begin
      in_valid = 1'b1;
      in_pc = 32'h1000 + 32'(4 * i);
      in_instr = 32'(i);
      idle(1);
    end
    in_valid = 1'b0;
    idle(1);
    chk("st_count", 64'(got_q.size()), 64'd100);
    if (got_q.size() == 100)
      for (int i = 0; i < 100; i++) chk("st_order", 64'(got_q[i]), 64'h1000 + 64'(4 * i));
    chk("st_stall", 64'(stall_cnt), 64'd0);

    // Stall counter saturation on the 4-bit instance.
    do_reset();
    out_ready = 1'b0;
    in_valid = 1'b1; in_pc = 32'h300; in_instr = 32'hD0;
    idle(1);
    in_valid = 1'b0;
    idle(20);
    chk("sat_stall4", 64'(d4_stall_cnt), 64'd15);
    chk("sat_stall16", 64'(stall_cnt), 64'd20);

    // Mixed traffic with flushes mid-stream; the model carries the expectations.
    do_reset();
    for (int i = 0; i < 40; i++) begin
      in_valid = (i % 3) != 0;
      out_ready = (i % 4) != 1;
      flush = (i == 17) || (i == 30);
      in_pc = 32'h4000 + 32'(4 * i);
      in_instr = 32'hE000 + 32'(i);
      idle(1);
    end
    flush = 1'b0; in_valid = 1'b0;
    idle(3);

    // Reset beats flush and accept while full.
    do_reset();
    out_ready = 1'b0;
    offer(32'h500, 32'hF0);
    offer(32'h504, 32'hF4);
    reset = 1'b1; flush = 1'b1; in_valid = 1'b1; in_pc = 32'h600;
    idle(1);
    reset = 1'b0; flush = 1'b0; in_valid = 1'b0;
    chk("rf_occ", 64'(occupancy), 64'd0);
    chk("rf_out_valid", {63'b0, out_valid}, 64'd0);
    chk("rf_in_ready", {63'b0, in_ready}, 64'd1);
    chk("rf_out_pc", 64'(out_pc), 64'd0);
    chk("rf_out_instr", 64'(out_instr), 64'd0);
    chk("rf_flush_cnt", 64'(flush_cnt), 64'd0);
    chk("rf_stall_cnt", 64'(stall_cnt), 64'd0);
    idle(2);

    check_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/if_id_skid.md
IF_ID_SKID -- requirements
Module: if_id_skid

Interface
REQ-001 Parameter XLEN, default 32, width of program-counter fields.
REQ-002 Parameter INSTR_W, default 32, width of instruction fields.
REQ-003 Parameter CNT_W, default 16, width of performance counters.
REQ-004 clock  input  1  rising-edge clock for all state.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 in_valid  input  1  fetch offers an entry this cycle.
REQ-007 in_ready  output  1  buffer can accept an entry this cycle.
REQ-008 in_pc  input  XLEN  PC of offered entry.
REQ-009 in_instr  input  INSTR_W  instruction of offered entry.
REQ-010 flush  input  1  branch/redirect; discard all held and offered entries.
REQ-011 out_valid  output  1  head entry presented to decode.
REQ-012 out_ready  input  1  decode consumes head entry this cycle.
REQ-013 out_pc  output  XLEN  PC of head entry, registered.
REQ-014 out_instr  output  INSTR_W  instruction of head entry, registered.
REQ-015 occupancy  output  2  held entries, 0..2.
REQ-016 flush_cnt  output  CNT_W  count of flush cycles.
REQ-017 stall_cnt  output  CNT_W  count of back-pressure cycles.

Function
REQ-018 Two-entry in-order buffer: head register plus skid register; states EMPTY (0), ONE (1), TWO (2); occupancy equals state.
REQ-019 in_ready = 1 in EMPTY and ONE, 0 in TWO; driven only from state register, no combinational path from out_ready or flush.
REQ-020 accept = in_valid & in_ready & !flush; pop = out_valid & out_ready & !flush.
REQ-021 out_valid = 1 in ONE and TWO; out_pc/out_instr always reflect the head register.
REQ-022 EMPTY: accept -> ONE, head <= input; else stay.
REQ-023 ONE: accept & pop -> ONE, head <= input; accept & !pop -> TWO, skid <= input; pop & !accept -> EMPTY; neither -> hold.
REQ-024 TWO: pop -> ONE, head <= skid; else hold all data.
REQ-025 Flush has priority over every other event: next state EMPTY, offered entry dropped, no pop counted; head/skid data registers hold their values (only validity cleared).
REQ-026 Entries leave in exactly the order accepted; no entry duplicated or lost except by flush.
REQ-027 Latency: accepted entry appears on out_* the cycle after acceptance when buffer was EMPTY or head popped in same cycle; full-throughput 1 entry/cycle when out_ready held high.
REQ-028 flush_cnt increments by 1 each cycle flush = 1, saturating at all-ones.
REQ-029 stall_cnt increments by 1 each cycle out_valid = 1 & out_ready = 0 & flush = 0, saturating at all-ones.
REQ-030 Counters change only on these events; no wrap-around.

Reset
REQ-031 reset = 1 at a rising edge forces state EMPTY, occupancy 0, out_valid 0, out_pc 0, out_instr 0, skid data 0, flush_cnt 0, stall_cnt 0.
REQ-032 Reset takes priority over flush, accept and pop; reset mid-operation discards all held entries.
REQ-033 in_ready = 1 in the first cycle after reset deasserts.

Verification
REQ-034 Reset, then in_valid=1 pc 0x100 instr 0x00000013, out_ready=1 -> next cycle out_valid=1, out_pc=0x100, occupancy=1.
REQ-035 out_ready=0, offer pc 0x100, 0x104, 0x108 back-to-back -> occupancy 1 then 2, in_ready=0 after second accept, 0x108 held off; raise out_ready -> outputs 0x100, 0x104, 0x108 in order; stall_cnt equals cycles of out_valid=1 & out_ready=0.
REQ-036 Occupancy 2, assert flush with in_valid=1 and out_ready=1 -> next cycle occupancy 0, out_valid 0, offered entry never appears, flush_cnt +1, out_pc unchanged.
REQ-037 Streaming 100 entries with out_ready=1 and in_valid=1 -> one entry out per cycle, occupancy stays 1, stall_cnt 0.
REQ-038 CNT_W=4, hold out_valid=1 & out_ready=0 for 20 cycles -> stall_cnt saturates at 15.
REQ-039 Assert reset while occupancy 2 and flush=1 -> all outputs at reset values next cycle, counters 0.
